// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the RV32I load/store sequencer.
//   - funct3 size/sign codes (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
//   - load/store major opcodes
//   - controller state encoding (lsu_state_t)
//   - helpers for byte enables, store-lane replication and misalignment
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_WB       = 3'd3,
    ST_TRAP     = 3'd4
  } lsu_state_t;

  // Reserved funct3 codes (011, 110, 111) fall through to word access.
  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] ea_lo);
    case (funct3)
      LSU_B, LSU_BU: lsu_be = 4'b0001 << ea_lo;
      LSU_H, LSU_HU: lsu_be = ea_lo[1] ? 4'b1100 : 4'b0011;
      default:       lsu_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      LSU_B, LSU_BU: lsu_store_data = {4{wdata[7:0]}};
      LSU_H, LSU_HU: lsu_store_data = {2{wdata[15:0]}};
      default:       lsu_store_data = wdata;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] ea_lo);
    case (funct3)
      LSU_B, LSU_BU: lsu_misaligned = 1'b0;
      LSU_H, LSU_HU: lsu_misaligned = ea_lo[0];
      default:       lsu_misaligned = (ea_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: single-outstanding valid/ready data-memory port.
//   mem_req_valid/mem_req_ready : request handshake
//   mem_addr/mem_we/mem_be/mem_wdata : request payload (word address, lane data)
//   mem_rsp_valid/mem_rdata : load response
// master = load/store controller, slave = data memory.
interface lsu_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational lane select and sign/zero extension of a load word.
//   rdata  : raw 32-bit word from memory
//   ea_lo  : effective-address byte offset
//   funct3 : size/sign code; bit 2 set selects zero extension
//   data   : aligned, extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext;

  always_comb begin
    byte_v = rdata[{ea_lo, 3'b000} +: 8];
    half_v = rdata[{ea_lo[1], 4'b0000} +: 16];
    sext   = ~funct3[2];
    case (funct3)
      LSU_B, LSU_BU: data = {{24{byte_v[7] & sext}}, byte_v};
      LSU_H, LSU_HU: data = {{16{half_v[15] & sext}}, half_v};
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer for the RV32I core.
// Accepts one decoded load/store, forms ea = base + imm, issues a single
// memory request, aligns/extends load data and pulses a register writeback.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   req_*                         : decoded request in, req_ready when idle
//   mem (lsu_ctrl_if.master)      : data-memory request/response port
//   wb_valid, wb_rd, wb_data      : one-cycle register-file writeback
//   busy                          : controller not idle
//   trap_valid, trap_addr         : misaligned-access trap (LSU_MISALIGN_TRAP_EN only)
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a request, req_ready=1
// ISSUE    | mem_req_valid=1, payload held until accepted
// WAIT_RSP | load issued, waiting for mem_rsp_valid
// WB       | writeback cycle (wb_valid unless rd==0)
// TRAP     | misaligned access reported for one cycle
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  lsu_ctrl_if.master      mem,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_addr
`endif
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("lsu_ctrl: only XLEN=32 is supported");
  end

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] ISSUE    = ST_ISSUE;
  localparam logic [2:0] WAIT_RSP = ST_WAIT_RSP;
  localparam logic [2:0] WB       = ST_WB;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [2:0] TRAP     = ST_TRAP;
`endif

  logic [2:0]      state;
  logic [2:0]      funct3_q;
  logic [1:0]      ea_lo_q;
  logic [XLEN-1:0] ea;
  logic [31:0]     align_data;

  assign ea        = req_base + req_imm;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  lsu_load_align u_align (
    .rdata  (mem.mem_rdata),
    .ea_lo  (ea_lo_q),
    .funct3 (funct3_q),
    .data   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      funct3_q          <= 3'b000;
      ea_lo_q           <= 2'b00;
      mem.mem_req_valid <= 1'b0;
      mem.mem_addr      <= '0;
      mem.mem_we        <= 1'b0;
      mem.mem_be        <= 4'b0000;
      mem.mem_wdata     <= '0;
      wb_valid          <= 1'b0;
      wb_rd             <= 5'd0;
      wb_data           <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_valid        <= 1'b0;
      trap_addr         <= '0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_q      <= req_funct3;
            ea_lo_q       <= ea[1:0];
            wb_rd         <= req_rd;
            mem.mem_addr  <= {ea[31:2], 2'b00};
            mem.mem_we    <= req_is_store;
            mem.mem_be    <= lsu_be(req_funct3, ea[1:0]);
            mem.mem_wdata <= lsu_store_data(req_funct3, req_wdata);
`ifdef LSU_MISALIGN_TRAP_EN
            if (lsu_misaligned(req_funct3, ea[1:0])) begin
              state      <= TRAP;
              trap_valid <= 1'b1;
              trap_addr  <= ea;
            end else begin
              state             <= ISSUE;
              mem.mem_req_valid <= 1'b1;
            end
`else
            state             <= ISSUE;
            mem.mem_req_valid <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (mem.mem_req_ready) begin
            mem.mem_req_valid <= 1'b0;
            // Stores complete on accept; only loads wait for data.
            state <= mem.mem_we ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem.mem_rsp_valid) begin
            wb_data  <= align_data;
            wb_valid <= (wb_rd != 5'd0);
            state    <= WB;
          end
        end
        WB: state <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        TRAP: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        trap_valid;
  logic [31:0] trap_addr;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_cnt    = 0;
  int wb_cnt    = 0;

  lsu_ctrl_if mif ();

  lsu_ctrl #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_base     (req_base),
    .req_imm      (req_imm),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem          (mif),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .trap_valid   (trap_valid),
    .trap_addr    (trap_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.mem_req_valid && mif.mem_req_ready) hs_cnt <= hs_cnt + 1;
    if (wb_valid) wb_cnt <= wb_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wdata, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_imm      = imm;
    req_wdata    = wdata;
    req_rd       = rd;
    tick();
    req_valid    = 1'b0;
  endtask

  // Zero-wait load: request in cycle 1, response in cycle 2, writeback in cycle 3.
  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data, input logic exp_wb);
    issue(1'b0, f3, base, imm, 32'h0, rd);
    check({tag, ".c1_req_valid"}, mif.mem_req_valid, 1);
    check({tag, ".c1_addr"}, mif.mem_addr, exp_addr);
    check({tag, ".c1_be"}, mif.mem_be, exp_be);
    check({tag, ".c1_we"}, mif.mem_we, 0);
    check({tag, ".c1_req_ready"}, req_ready, 0);
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    check({tag, ".c2_req_valid"}, mif.mem_req_valid, 0);
    check({tag, ".c2_wb_valid"}, wb_valid, 0);
    check({tag, ".c2_busy"}, busy, 1);
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rdata     = rdata;
    tick();
    mif.mem_rsp_valid = 1'b0;
    check({tag, ".c3_wb_valid"}, wb_valid, exp_wb);
    check({tag, ".c3_wb_data"}, wb_data, exp_data);
    check({tag, ".c3_wb_rd"}, wb_rd, rd);
    check({tag, ".c3_busy"}, busy, 1);
    tick();
    check({tag, ".c4_wb_valid"}, wb_valid, 0);
    check({tag, ".c4_req_ready"}, req_ready, 1);
  endtask

  initial begin
    int hs0;
    int wb0;
    rst_n             = 1'b0;
    req_valid         = 1'b0;
    req_is_store      = 1'b0;
    req_funct3        = 3'b000;
    req_base          = 32'h0;
    req_imm           = 32'h0;
    req_wdata         = 32'h0;
    req_rd            = 5'd0;
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rdata     = 32'h0;
    tick();
    tick();

    check("rst.req_ready", req_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.mem_req_valid", mif.mem_req_valid, 0);
    check("rst.mem_addr", mif.mem_addr, 32'h0);
    check("rst.mem_be", mif.mem_be, 4'h0);
    check("rst.wb_valid", wb_valid, 0);
    check("rst.wb_data", wb_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // LB with negative immediate: ea = 0x0FFF, byte lane 3.
    load_op("lb", LSU_B, 32'h0000_1000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000,
            32'h0000_0FFC, 4'b1000, 32'hFFFF_FF80, 1'b1);
    load_op("lhu", LSU_HU, 32'h0000_2000, 32'h0000_0002, 5'd6, 32'hBEEF_1234,
            32'h0000_2000, 4'b1100, 32'h0000_BEEF, 1'b1);
    load_op("lh", LSU_H, 32'h0000_2000, 32'h0000_0002, 5'd7, 32'hBEEF_1234,
            32'h0000_2000, 4'b1100, 32'hFFFF_BEEF, 1'b1);
    load_op("lbu", LSU_BU, 32'h0000_0010, 32'h0000_0001, 5'd8, 32'h1234_F056,
            32'h0000_0010, 4'b0010, 32'h0000_00F0, 1'b1);
    load_op("lb_pos", LSU_B, 32'h0000_0010, 32'h0000_0002, 5'd9, 32'h1234_F056,
            32'h0000_0010, 4'b0100, 32'h0000_0034, 1'b1);
    load_op("lw", LSU_W, 32'h0000_0100, 32'h0000_0020, 5'd10, 32'hDEAD_BEEF,
            32'h0000_0120, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    load_op("f3_111_as_w", 3'b111, 32'h0000_0100, 32'h0000_0024, 5'd11, 32'h8765_4321,
            32'h0000_0124, 4'b1111, 32'h8765_4321, 1'b1);
`ifndef LSU_MISALIGN_TRAP_EN
    // Misaligned half without trapping uses the ea[1] lane.
    load_op("lh_mis", LSU_H, 32'h0000_2000, 32'h0000_0003, 5'd12, 32'hBEEF_1234,
            32'h0000_2000, 4'b1100, 32'hFFFF_BEEF, 1'b1);
`endif

    // rd = 0: full transaction, no writeback strobe.
    wb0 = wb_cnt;
    load_op("lw_rd0", LSU_W, 32'h0000_0200, 32'h0000_0000, 5'd0, 32'h1111_2222,
            32'h0000_0200, 4'b1111, 32'h1111_2222, 1'b0);
    check("lw_rd0.wb_count", wb_cnt - wb0, 0);

    // SB at 0x3001.
    wb0 = wb_cnt;
    hs0 = hs_cnt;
    issue(1'b1, LSU_B, 32'h0000_3000, 32'h0000_0001, 32'h0000_00A5, 5'd3);
    check("sb.req_valid", mif.mem_req_valid, 1);
    check("sb.addr", mif.mem_addr, 32'h0000_3000);
    check("sb.be", mif.mem_be, 4'b0010);
    check("sb.wdata", mif.mem_wdata, 32'hA5A5_A5A5);
    check("sb.we", mif.mem_we, 1);
    check("sb.req_ready_c1", req_ready, 0);
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    check("sb.req_ready_c2", req_ready, 1);
    check("sb.req_valid_c2", mif.mem_req_valid, 0);
    tick();
    check("sb.handshakes", hs_cnt - hs0, 1);
    check("sb.no_wb", wb_cnt - wb0, 0);

    // SH at 0x3006.
    issue(1'b1, LSU_H, 32'h0000_3004, 32'h0000_0002, 32'h1234_ABCD, 5'd0);
    check("sh.be", mif.mem_be, 4'b1100);
    check("sh.wdata", mif.mem_wdata, 32'hABCD_ABCD);
    check("sh.addr", mif.mem_addr, 32'h0000_3004);
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    check("sh.req_ready", req_ready, 1);

    // SW with 5 cycles of backpressure; payload must hold.
    hs0 = hs_cnt;
    issue(1'b1, LSU_W, 32'h0000_5010, 32'hFFFF_FFF0, 32'hCAFE_F00D, 5'd0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d.req_valid", i), mif.mem_req_valid, 1);
      check($sformatf("bp%0d.addr", i), mif.mem_addr, 32'h0000_5000);
      check($sformatf("bp%0d.wdata", i), mif.mem_wdata, 32'hCAFE_F00D);
      check($sformatf("bp%0d.be", i), mif.mem_be, 4'b1111);
      check($sformatf("bp%0d.req_ready", i), req_ready, 0);
      tick();
    end
    check("bp.no_early_hs", hs_cnt - hs0, 0);
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    check("bp.req_ready_after", req_ready, 1);
    tick();
    check("bp.handshakes", hs_cnt - hs0, 1);

    // Reset while waiting for a load response; late response is ignored.
    wb0 = wb_cnt;
    issue(1'b0, LSU_W, 32'h0000_0300, 32'h0000_0000, 32'h0, 5'd7);
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    check("rstmid.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid.req_ready", req_ready, 1);
    check("rstmid.busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    mif.mem_rsp_valid = 1'b1;
    mif.mem_rdata     = 32'h5555_AAAA;
    tick();
    mif.mem_rsp_valid = 1'b0;
    check("rstmid.wb_valid", wb_valid, 0);
    check("rstmid.busy_after", busy, 0);
    tick();
    check("rstmid.wb_count", wb_cnt - wb0, 0);
    check("rstmid.wb_data", wb_data, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    hs0 = hs_cnt;
    issue(1'b0, LSU_W, 32'h0000_4000, 32'h0000_0002, 32'h0, 5'd4);
    check("trap.valid_c1", trap_valid, 1);
    check("trap.addr", trap_addr, 32'h0000_4002);
    check("trap.mem_req_valid", mif.mem_req_valid, 0);
    tick();
    check("trap.valid_c2", trap_valid, 0);
    check("trap.req_ready", req_ready, 1);
    check("trap.no_hs", hs_cnt - hs0, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer for the RV32I core.
- Takes a decoded load or store: base register value, sign-extended immediate, store data and rd.
- Forms the effective address and drives a single-outstanding valid/ready memory port.
- Aligns and sign- or zero-extends load data, then issues a one-cycle register-file writeback. Sits between decode/execute and the data-memory interface.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; elaborate-time error otherwise.

Ports:
- clk  in  1  core clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decoded load/store present
- req_ready  out  1  controller can accept (state IDLE)
- req_is_store  in  1  1 = store, 0 = load
- req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_base  in  32  rs1 value
- req_imm  in  32  sign-extended I/S immediate
- req_wdata  in  32  rs2 value (stores)
- req_rd  in  5  load destination
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  word address {ea[31:2],2'b00}
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rsp_valid  in  1  load data valid
- mem_rdata  in  32  load word
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  extended load data
- busy  out  1  state != IDLE
- trap_valid  out  1  misaligned-access trap (present only with LSU_MISALIGN_TRAP_EN)
- trap_addr  out  32  faulting effective address (present only with LSU_MISALIGN_TRAP_EN)

Behaviour:
- States: IDLE, ISSUE, WAIT_RSP, WB. With the feature enabled, also TRAP.
- Reset (async, rst_n=0):
  - state = IDLE.
  - mem_req_valid, mem_we, mem_be, wb_valid, busy, trap_valid = 0.
  - mem_addr, mem_wdata, wb_rd, wb_data, trap_addr = 0.
  - req_ready = (state==IDLE), so it reads 1 during reset. Upstream must hold req_valid=0 while rst_n=0.
- IDLE:
  - On req_valid: latch all req_* and ea = req_base + req_imm (mod 2^32, carry dropped), then go to ISSUE.
- ISSUE:
  - mem_req_valid=1.
  - mem_addr, mem_we, mem_be and mem_wdata are registered and stay stable until mem_req_ready.
  - On handshake: a store returns to IDLE (completes on accept, no writeback); a load goes to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid: capture the aligned and extended data into wb_data, then go to WB.
  - mem_rsp_valid in any other state is ignored.
- WB:
  - wb_valid=1 for exactly one cycle, then IDLE.
  - wb_valid is suppressed when rd=0; the state still passes through WB.
- Byte enables:
  - B: 4'b0001 << ea[1:0].
  - H: 4'b0011 << (2*ea[1]).
  - W: 4'b1111.
- Store data: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
- Load extraction:
  - Byte = rdata >> 8*ea[1:0]; half = rdata >> 16*ea[1].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- funct3 values 011, 110 and 111 are treated as W.
- Minimum load latency:
  - Request accepted at cycle 0; mem_req_valid in cycle 1.
  - With ready in cycle 1 and rsp in cycle 2, wb_valid is in cycle 3.
- Minimum store latency: accept at cycle 0, memory handshake at cycle 1, req_ready again at cycle 2.
- One request outstanding maximum; req_ready=0 throughout.
- Reset mid-operation: the transaction is abandoned and a late mem_rsp_valid is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access (H with ea[0]=1; W with ea[1:0]!=0) is detected in IDLE at accept and goes to TRAP instead of ISSUE.
  - No memory request and no writeback are issued.
  - TRAP drives trap_valid=1 and trap_addr=ea for one cycle, then IDLE.
- Undefined:
  - No trap ports.
  - A misaligned H uses the ea[1] lane; a misaligned W ignores ea[1:0].

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - Opcodes: OP_LOAD 7'b0000011, OP_STORE 7'b0100011.
  - The state enum lsu_state_t.
- Sub-module lsu_load_align: combinational lane select plus extend, taking (rdata, ea[1:0], funct3) to data.

Test Plan:
- LB, base=0x1000, imm=0xFFFFFFFF (ea=0x0FFF), rdata=0x80000000 -> mem_addr=0x0FFC, be=0001<<3, wb_data=0xFFFFFF80, wb_valid at cycle 3 with zero-wait memory.
- LHU at ea=0x2002, rdata=0xBEEF1234 -> wb_data=0x0000BEEF; LH at the same address -> 0xFFFFBEEF.
- SB at ea=0x3001, wdata=0x000000A5 -> be=0010, mem_wdata=0xA5A5A5A5, we=1, no wb_valid, req_ready back 1 cycle after handshake.
- mem_req_ready held low 5 cycles -> mem_req_valid and payload stable all 5 cycles, req_ready=0, single handshake.
- LW with rd=0 -> memory transaction completes, wb_valid never asserts. Reset asserted in WAIT_RSP, then rsp arrives -> ignored, state IDLE.
- With LSU_MISALIGN_TRAP_EN, LW at ea=0x4002 -> trap_valid for 1 cycle, trap_addr=0x4002, no mem_req_valid.
